pp_accumulator: RTL
===================

// Module: pp_accumulator
// PURPOSE
//  Downstream of the partial-product generator: takes one {denorm_pp, exp} pair per accepted cycle.
//  Aligns each pair to a signed fixed-point value and accumulates a dot-product into a register.
//  Emits the sum with a term count and an overflow flag. A later normalizer consumes the result.
//  Accumulator LSB = 2^-2 at exp 0 (mantissa LSB). Exponent bias is removed downstream.
// PARAMETERS
//  ACC_W      48  accumulator width, two's complement
//  MAX_TERMS  64  terms per dot-product; forced close when reached
//  CNT_W      7   term counter width; must hold MAX_TERMS
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  pp_valid   in   1      upstream term valid
//  pp_ready   out  1      accumulator can accept a term
//  denorm_pp  in   4      {sign, lead-one, mant[1:0]}; 4'b0000 means zero term
//  exp        in   6      alignment shift, 0..37 from upstream
//  pp_last    in   1      final term of this dot-product; sampled with the handshake
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  acc_out    out  ACC_W  signed sum
//  term_cnt   out  CNT_W  number of terms accepted, including zero terms
//  ovf        out  1      sticky overflow for this dot-product
// BEHAVIOUR
//  Transfer: a term is accepted when pp_valid && pp_ready at a rising edge.
//  Reset: state=ACCUM, pp_ready=1, out_valid=0, acc=0, term_cnt=0, ovf=0, pipe valid=0.
//    Reset mid-operation discards all in-flight terms and any held result.
//  Stage 1 (align), registered:
//    mag  = denorm_pp[2:0] as unsigned.
//    term = mag << exp, computed 3+63 bits wide.
//    Negate term if denorm_pp[3]==1 and mag!=0.
//    Register s1_term, s1_valid, s1_last.
//    A term whose magnitude does not fit ACC_W-1 bits sets align-overflow; s1_term is the low ACC_W bits.
//  Stage 2 (accumulate), when s1_valid:
//    acc <= acc + s1_term.
//    Signed overflow or align-overflow sets ovf (sticky).
//    term_cnt increments on each stage-1 accept.
//  FSM:
//    ACCUM: pp_ready=1. Close on an accept with pp_last=1, or on the accept that makes term_cnt==MAX_TERMS.
//      On close -> DRAIN with pp_ready=0 in the next cycle.
//    DRAIN: pp_ready=0. Wait for the last term to leave stage 2 (1 cycle) -> DONE.
//    DONE: out_valid=1. acc_out, term_cnt and ovf are held stable.
//      out_valid && out_ready -> ACCUM; acc, term_cnt and ovf clear on the same edge.
//  Latency: last term accepted at edge T -> out_valid=1 after edge T+2.
//  Throughput: 1 term/cycle in ACCUM. A new dot-product can start the cycle after result handoff.
//  Simultaneous events:
//    pp_valid is ignored in DRAIN/DONE (pp_ready=0).
//    pp_last on the MAX_TERMS-th term closes once, not twice.
//    out_ready without out_valid has no effect.
//  Empty dot-product is impossible: close needs at least one accepted term.
//  Zero terms (denorm_pp=0, any exp) add 0 but still count.
// CONFIGURATION
//  PP_ACC_SATURATE_EN defined: on signed overflow acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
//    Clamp direction follows the sign of s1_term; align-overflow clamps the same way. ovf still set.
//  PP_ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; ovf set.
// TESTING
//  1. Two terms: {0101,exp=2},{1110,exp=0,last} -> acc_out=14, term_cnt=2, ovf=0, out_valid 2 cycles after last.
//  2. Zero terms: {0000,exp=37},{1100,exp=3,last} -> acc_out=-32, term_cnt=2.
//  3. MAX_TERMS=4, four {0100,exp=0} with no pp_last -> close after the 4th, acc_out=16; pp_ready low until handoff.
//  4. Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, pp_ready=0. Pulse out_ready -> next term counted from 0.
//  5. ACC_W=8, {0111,exp=5,last} -> ovf=1; acc_out=127 with PP_ACC_SATURATE_EN, 0xE0 without.
//  6. Assert rst after 3 terms accepted -> next cycle all outputs at reset values; new sequence gives a clean sum.

Source files
------------

// File: rtl/pp_accumulator.sv
// Aligns {denorm_pp, exp} partial products to fixed point and accumulates a dot-product.
// Optional feature: PP_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module pp_accumulator #(
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned MAX_TERMS = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [3:0]       denorm_pp,
    input  logic [5:0]       exp,
    input  logic             pp_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);

    localparam int unsigned TERM_W = 66;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_pp_ready;
    logic              w_ready_nx;
    logic              r_out_valid;
    logic              w_valid_nx;
    logic              w_clear;

    logic              r_s1_valid;
    logic [ACC_W-1:0]  r_s1_term;
    logic              r_s1_aovf;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_term_cnt;
    logic              r_ovf;

    logic              w_accept;
    logic [2:0]        w_mag;
    logic [TERM_W-1:0] w_shift;
    logic [ACC_W-1:0]  w_low;
    logic              w_neg;
    logic              w_aovf;
    logic [ACC_W-1:0]  w_term;
    logic [ACC_W-1:0]  w_sum;
    logic              w_sovf;
    logic              w_at_max;

    assign w_accept = pp_valid && r_pp_ready;
    assign w_at_max = (r_term_cnt == CNT_W'(MAX_TERMS - 1));

    // Stage 1 alignment: shift full width so oversized terms can be detected
    assign w_mag   = denorm_pp[2:0];
    assign w_shift = TERM_W'(w_mag) << exp;
    assign w_low   = w_shift[ACC_W-1:0];
    assign w_aovf  = |w_shift[TERM_W-1:ACC_W-1];
    assign w_neg   = denorm_pp[3] && (w_mag != 3'd0);
    assign w_term  = w_neg ? (-w_low) : w_low;

    assign w_sum  = r_acc + r_s1_term;
    assign w_sovf = (r_acc[ACC_W-1] == r_s1_term[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef PP_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    // True sign of the term; the truncated s1_term sign is meaningless on align overflow
    logic r_s1_neg;
    always_ff @(posedge clk) begin
        if (rst) r_s1_neg <= 1'b0;
        else if (w_accept) r_s1_neg <= w_neg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_term  <= '0;
            r_s1_aovf  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_term <= w_term;
                r_s1_aovf <= w_aovf;
            end
        end
    end

    // Stage 2 accumulate plus term counting at the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_term_cnt <= '0;
        end else begin
            if (w_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_s1_valid) begin
`ifdef PP_ACC_SATURATE_EN
                if (w_sovf || r_s1_aovf) r_acc <= r_s1_neg ? ACC_MIN : ACC_MAX;
                else r_acc <= w_sum;
`else
                r_acc <= w_sum;
`endif
                if (w_sovf || r_s1_aovf) r_ovf <= 1'b1;
            end
            if (w_clear) r_term_cnt <= '0;
            else if (w_accept) r_term_cnt <= r_term_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_pp_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pp_ready  <= w_ready_nx;
            r_out_valid <= w_valid_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ready_nx = r_pp_ready;
        w_valid_nx = r_out_valid;
        w_clear    = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                if (w_accept && (pp_last || w_at_max)) begin
                    w_state_nx = ST_DRAIN;
                    w_ready_nx = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Last term sits in stage 1 for one cycle before reaching the accumulator
                if (!r_s1_valid) begin
                    w_state_nx = ST_DONE;
                    w_valid_nx = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx = ST_ACCUM;
                    w_ready_nx = 1'b1;
                    w_valid_nx = 1'b0;
                    w_clear    = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_ACCUM;
                w_ready_nx = 1'b1;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    assign pp_ready  = r_pp_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign term_cnt  = r_term_cnt;
    assign ovf       = r_ovf;

endmodule
